instruction_fetch: RTL and testbench

Fetch stage of the 16-bit TMVP core. It owns the program counter and reads each 16-bit instruction from external program memory over an 8-bit byte bus, as two request/acknowledge transactions. It presents the assembled word to the instruction decoder with a valid/ready handshake. It accepts jump redirects from the execute stage; this is the resolution point for ALU_JMP.

---
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage, reads 16-bit instructions over an 8-bit request/ack memory bus
// Ports:
//   clk, rst (async active-low)     clock and reset
//   enable                          allows a new fetch from IDLE / on VALID exit
//   mem_addr, mem_req               byte address {pc, byte_sel} and read request (registered)
//   mem_ack, mem_data               acknowledge and same-cycle data byte
//   instr, instr_pc, instr_valid    assembled word {hi, lo}, its PC, valid flag
//   instr_ready                     decoder accepts the word
//   branch_taken, branch_target     one-cycle redirect from execute
module instruction_fetch #(
    parameter int PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic [PC_WIDTH:0]   mem_addr,
    output logic                mem_req,
    input  logic                mem_ack,
    input  logic [7:0]          mem_data,
    output logic [15:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target
);
    typedef enum logic [1:0] {IDLE, FETCH_HI, FETCH_LO, VALID} state_t;
    state_t state, state_d;
    logic [PC_WIDTH-1:0] pc, pc_d, instr_pc_d;
    logic [PC_WIDTH:0]   addr_d;
    logic [15:0]         instr_d;
    logic                req_d, valid_d, pend, pend_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= {RESET_PC, 1'b0};
            pend        <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= valid_d;
            mem_req     <= req_d;
            mem_addr    <= addr_d;
            pend        <= pend_d;
        end
    end
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        valid_d    = instr_valid;
        req_d      = mem_req;
        addr_d     = mem_addr;
        pend_d     = pend;
        case (state)
            IDLE, VALID: begin
                // A branch wins over instr_ready: the word is consumed but pc is not incremented.
                pc_d = branch_taken ? branch_target
                     : (state == VALID && instr_ready) ? pc + 1'b1 : pc;
                if (state == IDLE || branch_taken || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = enable ? FETCH_HI : IDLE;
                    req_d   = enable;
                    addr_d  = {pc_d, 1'b0};
                end
            end
            default: begin
                // The in-flight byte request always completes; a redirect only
                // retargets pc and marks the returning data for discard.
                if (branch_taken) begin
                    pc_d   = branch_target;
                    pend_d = 1'b1;
                end
                if (mem_ack) begin
                    if (pend || branch_taken) begin
                        pend_d  = 1'b0;
                        state_d = FETCH_HI;
                        addr_d  = {pc_d, 1'b0};
                    end else if (state == FETCH_HI) begin
                        instr_d[15:8] = mem_data;
                        addr_d        = {pc, 1'b1};
                        state_d       = FETCH_LO;
                    end else begin
                        instr_d[7:0] = mem_data;
                        instr_pc_d   = pc;
                        req_d        = 1'b0;
                        valid_d      = 1'b1;
                        state_d      = VALID;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a stream-level model
module tb_instruction_fetch;
    localparam int PW = 12;
    logic          clk = 1'b0;
    logic          rst, enable, mem_req, mem_ack, instr_valid, instr_ready, branch_taken;
    logic [PW:0]   mem_addr;
    logic [7:0]    mem_data;
    logic [15:0]   instr;
    logic [PW-1:0] instr_pc, branch_target;
    always #5 clk = ~clk;
    instruction_fetch #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );
    logic [7:0]    mem [0:8191];
    int            ncmp = 0, nfail = 0, ninstr = 0;
    int            wcnt = 0, wlo = 0, whi = 0;
    bit            junk_ack = 0;
    logic [PW-1:0] exp_pc = '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] word(input logic [PW-1:0] a);
        return {mem[{a, 1'b0}], mem[{a, 1'b1}]};
    endfunction
    // One clock: play memory, advance the model (next word = last branch target,
    // else consumed PC + 1), then check the DUT's observable behaviour.
    task automatic cyc();
        logic pv, preq, hs, br, ack;
        logic [15:0] pi;
        logic [PW-1:0] ppc;
        logic [PW:0] pa;
        ack = 1'b0;
        if (mem_req) begin
            if (wcnt == 0) begin
                ack = 1'b1;
                wcnt = $urandom_range(whi, wlo);
            end else wcnt--;
        end else ack = junk_ack && ($urandom_range(3, 0) == 0);
        mem_ack  = ack;
        mem_data = (ack && mem_req) ? mem[mem_addr] : 8'($urandom);
        pv = instr_valid; preq = mem_req; pi = instr; ppc = instr_pc; pa = mem_addr;
        br = branch_taken; hs = instr_valid && instr_ready;
        if (br) exp_pc = branch_target;
        else if (hs) exp_pc = instr_pc + 12'd1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (pv && (hs || br)) chk("valid_drop", instr_valid, 0);
        else if (pv) begin
            chk("valid_hold", instr_valid, 1);
            chk("instr_hold", instr, pi);
            chk("pc_hold", instr_pc, ppc);
        end else if (instr_valid) begin
            ninstr++;
            chk("new_pc", instr_pc, exp_pc);
            chk("new_instr", instr, word(exp_pc));
        end
        if (preq && !ack) begin
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, pa);
        end
    endtask
    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 50) begin
            cyc();
            n++;
        end
        chk(tag, instr_valid, 1);
    endtask
    initial begin
        int n;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h51; mem[1] = 8'h23; mem[13'h143] = 8'hFF;
        rst = 1'b0; enable = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
        branch_target = '0; mem_ack = 1'b0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        rst = 1'b1; enable = 1'b1;
        cyc();
        chk("t1_req", mem_req, 1);
        chk("t1_addr_hi", mem_addr, 13'h000);
        cyc();
        chk("t1_addr_lo", mem_addr, 13'h001);
        chk("t1_req_lo", mem_req, 1);
        chk("t1_not_valid", instr_valid, 0);
        cyc();
        chk("t1_valid", instr_valid, 1);
        chk("t1_instr", instr, 16'h5123);
        chk("t1_pc", instr_pc, 12'h000);
        chk("t1_req_drop", mem_req, 0);
        wlo = 2; whi = 2; wcnt = 2;
        repeat (5) cyc();
        chk("t2_hold", instr, 16'h5123);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("t2_next_addr", mem_addr, 13'h002);
        chk("t2_next_req", mem_req, 1);
        wait_valid("t2_valid");
        chk("t2_pc", instr_pc, 12'h001);
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 12'h0A0;
        cyc();
        instr_ready = 1'b0; branch_taken = 1'b0;
        chk("t3_valid_low", instr_valid, 0);
        chk("t3_addr", mem_addr, 13'h140);
        wait_valid("t3_valid");
        chk("t3_pc", instr_pc, 12'h0A0);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        n = 0;
        while (!mem_addr[0] && n < 20) begin
            cyc();
            n++;
        end
        chk("t4_in_lo", mem_addr, 13'h143);
        branch_taken = 1'b1; branch_target = 12'h010;
        cyc();
        branch_taken = 1'b0;
        n = 0;
        while (mem_addr != 13'h020 && n < 20) begin
            chk("t4_no_valid", instr_valid, 0);
            cyc();
            n++;
        end
        chk("t4_redirect", mem_addr, 13'h020);
        wait_valid("t4_valid");
        chk("t4_pc", instr_pc, 12'h010);
        branch_taken = 1'b1; branch_target = 12'hFFF;
        cyc();
        branch_taken = 1'b0;
        wait_valid("t5_valid");
        chk("t5_pc", instr_pc, 12'hFFF);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("t5_wrap_addr", mem_addr, 13'h0000);
        wait_valid("t5_wrap_valid");
        chk("t5_wrap_pc", instr_pc, 12'h000);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("t6_req_before", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_req", mem_req, 0);
        chk("t6_async_valid", instr_valid, 0);
        chk("t6_async_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b1; exp_pc = '0; wcnt = 0;
        cyc();
        chk("t6_restart_req", mem_req, 1);
        chk("t6_restart_addr", mem_addr, 0);
        wait_valid("t6_valid");
        chk("t6_instr", instr, 16'h5123);
        wlo = 0; whi = 3; junk_ack = 1;
        repeat (3000) begin
            enable        = $urandom_range(7, 0) != 0;
            instr_ready   = 1'($urandom_range(1, 0));
            branch_taken  = $urandom_range(15, 0) == 0;
            branch_target = ($urandom_range(3, 0) == 0) ? 12'hFFF : 12'($urandom);
            cyc();
        end
        chk("progress", ninstr > 100, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
